// File: rtl/tile_test_sequencer_if.sv
// Handshake and grid bus between the tile test sequencer and its controller.
// Carries the abort line only when TILE_TEST_SEQUENCER_ABORT_EN is defined.
interface tile_test_sequencer_if;
  logic       start;
  logic [7:0] num_patterns;
  logic [7:0] golden_sig;
  logic [3:0] dut_out;
  logic [3:0] dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] sig;
  logic [7:0] pattern_idx;
`ifdef TILE_TEST_SEQUENCER_ABORT_EN
  logic       abort;

  modport master (
    output start, num_patterns, golden_sig,
    output dut_out, abort,
    input  dut_in, busy, done, pass,
    input  sig, pattern_idx
  );

  modport slave (
    input  start, num_patterns, golden_sig,
    input  dut_out, abort,
    output dut_in, busy, done, pass,
    output sig, pattern_idx
  );
`else
  modport master (
    output start, num_patterns, golden_sig,
    output dut_out,
    input  dut_in, busy, done, pass,
    input  sig, pattern_idx
  );

  modport slave (
    input  start, num_patterns, golden_sig,
    input  dut_out,
    output dut_in, busy, done, pass,
    output sig, pattern_idx
  );
`endif
endinterface

// File: rtl/tile_test_sequencer.sv
// LFSR-driven 2x2 tile grid tester with MISR signature compaction.
// Optional run abort via TILE_TEST_SEQUENCER_ABORT_EN.
module tile_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  tile_test_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] lfsr;
  logic [3:0] cnt;
  logic [7:0] num_lat;
  logic [3:0] dut_in;
  logic [7:0] sig;
  logic [7:0] idx;
  logic       done;
  logic       pass;
  logic       abort;
  logic       aborting;
  logic [7:0] idx_inc;
  logic [7:0] sig_nx;
  logic [3:0] lfsr_nx;

`ifdef TILE_TEST_SEQUENCER_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif

  assign idx_inc = idx + 8'd1;
  assign lfsr_nx = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  assign sig_nx  = {sig[6:0], sig[7] ^ sig[5] ^ sig[4] ^ sig[3]}
                 ^ {4'b0000, bus.dut_out};
  assign aborting = abort &&
    (state inside {APPLY, SETTLE, CAPTURE});

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_nx = (bus.num_patterns == 8'd0) ? DONE : APPLY;
      end
      APPLY: begin
        state_nx = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST)
          state_nx = CAPTURE;
      end
      CAPTURE: begin
        state_nx = (idx_inc == num_lat) ? DONE : APPLY;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (aborting)
      state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= 4'b0001;
      cnt     <= 4'd0;
      num_lat <= 8'd0;
      dut_in  <= 4'd0;
      sig     <= 8'd0;
      idx     <= 8'd0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sig     <= 8'd0;
            idx     <= 8'd0;
            pass    <= 1'b0;
            lfsr    <= 4'b0001;
            num_lat <= bus.num_patterns;
          end
        end
        APPLY: begin
          cnt <= 4'd0;
          if (!aborting)
            dut_in <= lfsr;
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
        end
        CAPTURE: begin
          // an aborted capture leaves the partial signature intact
          if (!aborting) begin
            sig  <= sig_nx;
            lfsr <= lfsr_nx;
            idx  <= idx_inc;
          end
        end
        DONE: begin
          pass <= (sig == bus.golden_sig);
        end
        default: begin
        end
      endcase
      if (aborting)
        pass <= 1'b0;
    end
  end

  assign bus.dut_in      = dut_in;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.sig         = sig;
  assign bus.pattern_idx = idx;

endmodule

// File: tb/tb_tile_test_sequencer.sv
// Directed vector bench for tile_test_sequencer (SETTLE_CYCLES=2).
module tb_tile_test_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] mask;
  int         checks;
  int         failures;

  tile_test_sequencer_if bus();

  tile_test_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.dut_out = bus.dut_in ^ mask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [7:0] golden;
    logic [3:0] m;
    logic [7:0] sig;
    logic       pass;
    logic [7:0] idx;
    logic [3:0] din;
    int         lat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_sig(input int n,
                                           input logic [3:0] m);
    logic [3:0] l;
    logic [7:0] s;
    l = 4'b0001;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {4'h0, l ^ m};
      l = {l[2:0], l[3] ^ l[2]};
    end
    return s;
  endfunction

  task automatic run(input logic [7:0] n,
                     input logic [7:0] g,
                     input logic [3:0] m,
                     output int lat);
    @(negedge clk);
    mask = m;
    bus.num_patterns = n;
    bus.golden_sig = g;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.num_patterns = 8'hFF;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    lat = -1;
    for (int c = 1; c <= int'(n) * 4 + 40; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == 2);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    int   lat;
    logic p;
    run(v.n, v.golden, v.m, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
    chk({tag, "_sig"}, 32'(bus.sig), 32'(v.sig));
    chk({tag, "_pass"}, 32'(bus.pass), 32'(v.pass));
    chk({tag, "_idx"}, 32'(bus.pattern_idx), 32'(v.idx));
    chk({tag, "_din"}, 32'(bus.dut_in), 32'(v.din));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    p = bus.pass;
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass_hold"}, 32'(bus.pass), 32'(p));
  endtask

  initial begin
    int   lat;
    logic saw_done;
    checks = 0;
    failures = 0;
    mask = 4'h0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.num_patterns = 8'd0;
    bus.golden_sig = 8'd0;
`ifdef TILE_TEST_SEQUENCER_ABORT_EN
    bus.abort = 1'b0;
`endif

    vt[0] = '{8'd1, 8'h01, 4'h0, 8'h01, 1'b1, 8'd1, 4'h1, 5};
    vt[1] = '{8'd2, 8'h00, 4'h0, 8'h00, 1'b1, 8'd2, 4'h2, 9};
    vt[2] = '{8'd0, 8'h00, 4'h0, 8'h00, 1'b1, 8'd0, 4'h2, 1};
    vt[3] = '{8'd0, 8'h5A, 4'h0, 8'h00, 1'b0, 8'd0, 4'h2, 1};
    vt[4] = '{8'd3, 8'h00, 4'h0, 8'h04, 1'b0, 8'd3, 4'h4, 13};
    vt[5] = '{8'd3, 8'h04, 4'h0, 8'h04, 1'b1, 8'd3, 4'h4, 13};
    vt[6] = '{8'd2, 8'h10, 4'hF, 8'h10, 1'b1, 8'd2, 4'h2, 9};
    vt[7] = '{8'd4, 8'h00, 4'h0, 8'h01, 1'b0, 8'd4, 4'h9, 17};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", 32'(bus.dut_in), 32'd0);
    chk("rst_sig", 32'(bus.sig), 32'd0);
    chk("rst_idx", 32'(bus.pattern_idx), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      check_vec(vt[i], $sformatf("vec%0d", i));

    // sixteen patterns wrap the LFSR back to its seed
    run(8'd16, 8'h00, 4'h0, lat);
    chk("wrap_lat", 32'(lat), 32'd65);
    chk("wrap_din", 32'(bus.dut_in), 32'h1);
    chk("wrap_idx", 32'(bus.pattern_idx), 32'd16);
    chk("wrap_sig", 32'(bus.sig), 32'(model_sig(16, 4'h0)));

    // asynchronous reset while pattern 3 settles
    @(negedge clk);
    mask = 4'h0;
    bus.num_patterns = 8'd5;
    bus.golden_sig = 8'h00;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_din_p3", 32'(bus.dut_in), 32'h4);
    chk("mid_idx", 32'(bus.pattern_idx), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_din", 32'(bus.dut_in), 32'd0);
    chk("arst_sig", 32'(bus.sig), 32'd0);
    chk("arst_idx", 32'(bus.pattern_idx), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_pass", 32'(bus.pass), 32'd0);
    saw_done = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | bus.done;
    end
    chk("arst_no_done", 32'(saw_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_vec(vt[0], "restart");

`ifdef TILE_TEST_SEQUENCER_ABORT_EN
    @(negedge clk);
    bus.num_patterns = 8'd3;
    bus.golden_sig = 8'h01;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | bus.done;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_pass", 32'(bus.pass), 32'd0);
    chk("abort_idx", 32'(bus.pattern_idx), 32'd1);
    chk("abort_sig", 32'(bus.sig), 32'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_test_sequencer.md
TILE_TEST_SEQUENCER -- requirements
Module: tile_test_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: wait cycles (0..15) between applying a pattern and capturing the grid response.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port start  input  1  one-cycle request to begin a test run; sampled only in IDLE.
REQ-005 Port num_patterns  input  8  number of patterns to apply; latched at accepted start.
REQ-006 Port golden_sig  input  8  expected signature; compared in DONE.
REQ-007 Port dut_out  input  4  response from 2x2 tile grid outputs.
REQ-008 Port dut_in  output  4  stimulus to 2x2 tile grid inputs, registered.
REQ-009 Port busy  output  1  high in every state except IDLE.
REQ-010 Port done  output  1  one-cycle pulse at run completion.
REQ-011 Port pass  output  1  sig==golden_sig result, held until next accepted start.
REQ-012 Port sig  output  8  running MISR signature.
REQ-013 Port pattern_idx  output  8  count of patterns captured in current run.

Function
REQ-014 FSM states SHALL be IDLE, APPLY, SETTLE, CAPTURE, DONE.
REQ-015 IDLE + start + num_patterns!=0 -> APPLY; clears sig, pattern_idx, pass; LFSR reloads 4'b0001.
REQ-016 IDLE + start + num_patterns==0 -> DONE directly; sig stays 8'h00; pass = (golden_sig==8'h00).
REQ-017 APPLY (1 cycle): dut_in <= LFSR; -> SETTLE, or -> CAPTURE if SETTLE_CYCLES==0.
REQ-018 SETTLE lasts exactly SETTLE_CYCLES cycles, dut_in held, then -> CAPTURE.
REQ-019 CAPTURE (1 cycle): sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ {4'b0000, dut_out}; LFSR advances; pattern_idx increments.
REQ-020 CAPTURE -> DONE when incremented pattern_idx equals latched num_patterns, else -> APPLY.
REQ-021 LFSR SHALL be 4-bit, next = {l[2:0], l[3]^l[2]}, period 15; wraps to 4'b0001 after 15 advances, no stall.
REQ-022 DONE (1 cycle): done=1, pass <= (sig==golden_sig); -> IDLE.
REQ-023 Per pattern latency SHALL be 2+SETTLE_CYCLES cycles; done high N*(2+SETTLE_CYCLES)+1 cycles after the start edge.
REQ-024 start while busy SHALL be ignored; num_patterns/golden_sig changes mid-run SHALL not affect the run (golden_sig sampled in DONE).
REQ-025 dut_in SHALL hold its last value in IDLE and DONE.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, dut_in=0, sig=0, pattern_idx=0, busy=0, done=0, pass=0, LFSR=4'b0001, also mid-run.
REQ-027 First start after rst_n deassertion SHALL be accepted.

Configuration
REQ-028 Macro TILE_TEST_SEQUENCER_ABORT_EN defined: extra input port abort (1 bit); abort high in APPLY/SETTLE/CAPTURE -> IDLE next cycle, no done pulse, pass=0, sig/pattern_idx frozen.
REQ-029 Macro undefined: no abort port; run always completes to DONE.

Verification
REQ-030 Loopback (dut_out=dut_in), num_patterns=1, golden 8'h01, SETTLE_CYCLES=2 -> dut_in=4'h1, sig=8'h01, done at cycle 5, pass=1.
REQ-031 Loopback, num_patterns=2, golden 8'h00 -> dut_in sequence 1,2; sig=8'h00; pass=1; done at cycle 9.
REQ-032 num_patterns=0, golden 8'h00 -> done next-but-one cycle, pass=1, dut_in unchanged; golden 8'h5A -> pass=0.
REQ-033 num_patterns=16 loopback -> dut_in pattern 16 equals 4'h1 (LFSR wrap), pattern_idx=16 at done.
REQ-034 rst_n low during SETTLE of pattern 3 -> all outputs zero asynchronously, no done; restart succeeds.
REQ-035 With TILE_TEST_SEQUENCER_ABORT_EN: abort during pattern 2 -> IDLE, done never pulses, pass=0.
